// File: rtl/d5m_tx_pkg.sv
// Shared types and constants for the D5M sensor-side stream generator.
// The LFSR constants are only consumed when D5M_STREAM_TX_LFSR_EN is defined.
package d5m_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FRONT,
        LINE,
        HBLANK,
        VBLANK
    } tx_state_t;

    typedef enum logic [1:0] {
        CH_R,
        CH_G,
        CH_B
    } bayer_ch_t;

    localparam logic [1:0]  MODE_BARS  = 2'd0;
    localparam logic [1:0]  MODE_RAMP  = 2'd1;
    localparam logic [1:0]  MODE_CHECK = 2'd2;
    localparam logic [1:0]  MODE_AUX   = 2'd3;

    localparam logic [11:0] BAR_HI     = 12'hFFF;
    localparam logic [11:0] BAR_LO     = 12'h000;
    localparam logic [11:0] GREY_MID   = 12'h800;

    // Fibonacci taps for x^12+x^6+x^4+x+1: state bits 11, 5, 3, 0.
    localparam logic [11:0] LFSR_SEED  = 12'hACE;
    localparam logic [11:0] LFSR_TAPS  = 12'h829;

    function automatic logic [11:0] lfsr_step(input logic [11:0] s);
        return {s[10:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/d5m_tx_pattern.sv
// Pixel value generator: Bayer channel select plus pattern lookup.
// Mode 3 is an LFSR when D5M_STREAM_TX_LFSR_EN is defined, flat mid-grey otherwise.
module d5m_tx_pattern
    import d5m_tx_pkg::*;
(
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        seed_load,
    input  logic        advance,
    input  logic [1:0]  mode,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [2:0]  bar,
    output logic [11:0] pixel
);

    bayer_ch_t   chan;
    logic        bar_bit;
    logic [11:0] aux_val;

`ifdef D5M_STREAM_TX_LFSR_EN
    logic [11:0] lfsr_reg;

    // Holds the value for the next active pixel; reseeded at every frame start.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            lfsr_reg <= LFSR_SEED;
        end else if (seed_load) begin
            lfsr_reg <= LFSR_SEED;
        end else if (advance) begin
            lfsr_reg <= lfsr_step(lfsr_reg);
        end
    end

    assign aux_val = lfsr_reg;
`else
    logic unused_lfsr_ctl;
    assign unused_lfsr_ctl = ^{iCLK, iRST_N, seed_load, advance};
    assign aux_val = GREY_MID;
`endif

    logic unused_xy_bits;
    assign unused_xy_bits = ^{x[15:12], y[15:6], y[4:1]};

    always_comb begin
        if (y[0]) begin
            chan = x[0] ? CH_G : CH_B;
        end else begin
            chan = x[0] ? CH_R : CH_G;
        end

        case (chan)
            CH_R:    bar_bit = bar[2];
            CH_G:    bar_bit = bar[1];
            default: bar_bit = bar[0];
        endcase

        case (mode)
            MODE_BARS:  pixel = bar_bit ? BAR_HI : BAR_LO;
            MODE_RAMP:  pixel = x[11:0];
            MODE_CHECK: pixel = (x[5] ^ y[5]) ? BAR_HI : BAR_LO;
            default:    pixel = aux_val;
        endcase
    end

endmodule

// File: rtl/d5m_stream_tx.sv
// D5M camera-side stream generator: FVAL/LVAL timing FSM, geometry counters, registered outputs.
// Optional LFSR test pattern (mode 3) is enabled by defining D5M_STREAM_TX_LFSR_EN.
module d5m_stream_tx
    import d5m_tx_pkg::*;
#(
    parameter int ACTIVE_PIXELS = 1280,
    parameter int ACTIVE_LINES  = 960,
    parameter int H_BLANK       = 64,
    parameter int V_BLANK       = 512,
    parameter int FRONT_CYC     = 8
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iSTART,
    input  logic        iEND,
    input  logic [1:0]  iMODE,
    output logic [11:0] oDATA,
    output logic        oFVAL,
    output logic        oLVAL,
    output logic [31:0] oFrame_Cont,
    output logic        oBUSY
);

    localparam int          BAR_W      = ACTIVE_PIXELS / 8;
    localparam logic [15:0] PIX_LAST   = 16'(ACTIVE_PIXELS - 1);
    localparam logic [15:0] LINE_LAST  = 16'(ACTIVE_LINES - 1);
    localparam logic [15:0] HB_LAST    = 16'(H_BLANK - 1);
    localparam logic [15:0] VB_LAST    = 16'(V_BLANK - 1);
    localparam logic [15:0] FRONT_LAST = 16'(FRONT_CYC - 1);
    localparam logic [15:0] BAR_LAST   = 16'(BAR_W - 1);

    tx_state_t   state_reg, state_next;
    logic [15:0] x_reg, x_next;
    logic [15:0] y_reg, y_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [15:0] bar_cnt_reg, bar_cnt_next;
    logic [2:0]  bar_reg, bar_next;
    logic [1:0]  mode_reg, mode_next;
    logic        stop_reg, stop_next;
    logic [31:0] frame_cont_reg, frame_cont_next;

    logic [11:0] data_reg;
    logic        fval_reg, lval_reg, busy_reg;
    logic        fval_next, lval_next, seed_load;
    logic [11:0] pixel;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_reg      <= IDLE;
            x_reg          <= '0;
            y_reg          <= '0;
            cnt_reg        <= '0;
            bar_cnt_reg    <= '0;
            bar_reg        <= '0;
            mode_reg       <= MODE_BARS;
            stop_reg       <= 1'b0;
            frame_cont_reg <= '0;
            data_reg       <= '0;
            fval_reg       <= 1'b0;
            lval_reg       <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            x_reg          <= x_next;
            y_reg          <= y_next;
            cnt_reg        <= cnt_next;
            bar_cnt_reg    <= bar_cnt_next;
            bar_reg        <= bar_next;
            mode_reg       <= mode_next;
            stop_reg       <= stop_next;
            frame_cont_reg <= frame_cont_next;
            data_reg       <= lval_next ? pixel : 12'h000;
            fval_reg       <= fval_next;
            lval_reg       <= lval_next;
            busy_reg       <= (state_next != IDLE);
        end
    end

    // A stop request seen on the very last VBLANK cycle still takes effect.
    always_comb begin
        state_next      = state_reg;
        x_next          = x_reg;
        y_next          = y_reg;
        cnt_next        = cnt_reg;
        bar_cnt_next    = bar_cnt_reg;
        bar_next        = bar_reg;
        mode_next       = mode_reg;
        stop_next       = stop_reg | iEND;
        frame_cont_next = frame_cont_reg;

        case (state_reg)
            IDLE: begin
                if (iSTART && !iEND) begin
                    state_next = FRONT;
                    cnt_next   = '0;
                    mode_next  = iMODE;
                    stop_next  = 1'b0;
                end
            end
            FRONT: begin
                if (cnt_reg == FRONT_LAST) begin
                    state_next   = LINE;
                    x_next       = '0;
                    y_next       = '0;
                    bar_next     = '0;
                    bar_cnt_next = '0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            LINE: begin
                if (x_reg == PIX_LAST) begin
                    cnt_next = '0;
                    if (y_reg == LINE_LAST) begin
                        state_next      = VBLANK;
                        frame_cont_next = frame_cont_reg + 32'd1;
                    end else begin
                        state_next = HBLANK;
                    end
                end else begin
                    x_next = x_reg + 16'd1;
                    if (bar_cnt_reg == BAR_LAST) begin
                        bar_cnt_next = '0;
                        bar_next     = bar_reg + 3'd1;
                    end else begin
                        bar_cnt_next = bar_cnt_reg + 16'd1;
                    end
                end
            end
            HBLANK: begin
                if (cnt_reg == HB_LAST) begin
                    state_next   = LINE;
                    x_next       = '0;
                    y_next       = y_reg + 16'd1;
                    bar_next     = '0;
                    bar_cnt_next = '0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            VBLANK: begin
                if (cnt_reg == VB_LAST) begin
                    if (stop_reg || iEND) begin
                        state_next = IDLE;
                    end else begin
                        state_next = FRONT;
                        cnt_next   = '0;
                        mode_next  = iMODE;
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign lval_next = (state_next == LINE);
    assign fval_next = (state_next == FRONT) || (state_next == LINE) || (state_next == HBLANK);
    assign seed_load = (state_next == FRONT) && (state_reg != FRONT);

    // Pattern sees the coordinates of the pixel about to be registered, so oDATA lines up with oLVAL.
    d5m_tx_pattern u_pattern (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .seed_load (seed_load),
        .advance   (lval_next),
        .mode      (mode_reg),
        .x         (x_next),
        .y         (y_next),
        .bar       (bar_next),
        .pixel     (pixel)
    );

    assign oDATA       = data_reg;
    assign oFVAL       = fval_reg;
    assign oLVAL       = lval_reg;
    assign oFrame_Cont = frame_cont_reg;
    assign oBUSY       = busy_reg;

endmodule
